// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the pipeline WB stage has fixed priority; long-latency
// results are bypassed when the queue is empty, otherwise buffered in a small FIFO.
module wb_arbiter #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwe,
    input  logic [4:0]       pwa,
    input  logic [WIDTH-1:0] pwd,
    input  logic             lv,
    input  logic [4:0]       lwa,
    input  logic [WIDTH-1:0] lwd,
    output logic             lrdy,
    input  logic [4:0]       chk_a1,
    input  logic [4:0]       chk_a2,
    output logic             chk_hit1,
    output logic             chk_hit2,
    output logic             stall_req,
    output logic             we,
    output logic [4:0]       wa,
    output logic [WIDTH-1:0] wd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]       addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WW-1:0]    wait_reg, wait_next;
    logic             we_reg, we_next;
    logic [4:0]       wa_reg, wa_next;
    logic [WIDTH-1:0] wd_reg, wd_next;

    logic             empty, full, pipe_sel, accept, pop, bypass, push;
    logic [DEPTH-1:0] hit1_vec, hit2_vec;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign lrdy     = rst_n && !full;
    assign accept   = lv && lrdy;
    assign pipe_sel = pwe && (pwa != 5'd0);
    assign pop      = !pipe_sel && !empty;
    assign bypass   = !pipe_sel && empty && accept && (lwa != 5'd0);
    // Writes to r0 are accepted from the unit but never queued.
    assign push     = accept && (lwa != 5'd0) && !bypass;

    always_comb begin
        we_next     = 1'b0;
        wa_next     = wa_reg;
        wd_next     = wd_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        wait_next   = wait_reg;
        if (pipe_sel) begin
            we_next = 1'b1;
            wa_next = pwa;
            wd_next = pwd;
        end else if (pop) begin
            we_next = 1'b1;
            wa_next = addr_mem[rd_ptr_reg];
            wd_next = data_mem[rd_ptr_reg];
        end else if (bypass) begin
            we_next = 1'b1;
            wa_next = lwa;
            wd_next = lwd;
        end
        if (pop)
            rd_ptr_next = rd_ptr_reg + PW'(1);
        if (push)
            wr_ptr_next = wr_ptr_reg + PW'(1);
        count_next = count_reg + CW'(push) - CW'(pop);
        if (empty || pop)
            wait_next = '0;
        else if (wait_reg != WW'(MAX_WAIT))
            wait_next = wait_reg + WW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            wait_reg   <= '0;
            we_reg     <= 1'b0;
            wa_reg     <= '0;
            wd_reg     <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            wait_reg   <= wait_next;
            we_reg     <= we_next;
            wa_reg     <= wa_next;
            wd_reg     <= wd_next;
        end
    end

    // Storage needs no reset: entry validity is derived from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= lwa;
            data_mem[wr_ptr_reg] <= lwd;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [PW-1:0] offset;
        logic          valid;
        assign offset       = PW'(gi) - rd_ptr_reg;
        assign valid        = (CW'(offset) < count_reg);
        assign hit1_vec[gi] = valid && (addr_mem[gi] == chk_a1);
        assign hit2_vec[gi] = valid && (addr_mem[gi] == chk_a2);
    end

    assign chk_hit1  = (chk_a1 != 5'd0) && ((|hit1_vec) || (we_reg && (wa_reg == chk_a1)));
    assign chk_hit2  = (chk_a2 != 5'd0) && ((|hit2_vec) || (we_reg && (wa_reg == chk_a2)));
    assign stall_req = full || (wait_reg == WW'(MAX_WAIT));
    assign we        = we_reg;
    assign wa        = wa_reg;
    assign wd        = wd_reg;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table of per-cycle inputs and expected outputs, with the
// registered writeback results routed through a scoreboard queue, plus a mid-run reset sequence.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwe, lv;
    logic [4:0]  pwa, lwa, chk_a1, chk_a2;
    logic [31:0] pwd, lwd;
    logic        lrdy, chk_hit1, chk_hit2, stall_req, we;
    logic [4:0]  wa;
    logic [31:0] wd;

    always #5 clk = ~clk;

    wb_arbiter #(.WIDTH(32), .DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .pwe(pwe), .pwa(pwa), .pwd(pwd),
        .lv(lv), .lwa(lwa), .lwd(lwd), .lrdy(lrdy),
        .chk_a1(chk_a1), .chk_a2(chk_a2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
        .stall_req(stall_req), .we(we), .wa(wa), .wd(wd)
    );

    typedef struct {
        string       name;
        logic        pwe;
        logic [4:0]  pwa;
        logic [31:0] pwd;
        logic        lv;
        logic [4:0]  lwa;
        logic [31:0] lwd;
        logic [4:0]  ca;
        logic        lrdy;
        logic        stall;
        logic        hit;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic void add(input string name, input logic p_we, input logic [4:0] p_wa,
                                input logic [31:0] p_wd, input logic l_v, input logic [4:0] l_wa,
                                input logic [31:0] l_wd, input logic [4:0] ca, input logic e_rdy,
                                input logic e_stall, input logic e_hit, input logic e_we,
                                input logic [4:0] e_wa, input logic [31:0] e_wd);
        vec_t v;
        v.name = name;   v.pwe = p_we;    v.pwa = p_wa;   v.pwd = p_wd;
        v.lv = l_v;      v.lwa = l_wa;    v.lwd = l_wd;   v.ca = ca;
        v.lrdy = e_rdy;  v.stall = e_stall; v.hit = e_hit;
        v.we = e_we;     v.wa = e_wa;     v.wd = e_wd;
        vecs.push_back(v);
    endfunction

    initial begin
        exp_t e;
        rst_n = 1'b0; pwe = 1'b0; pwa = '0; pwd = '0; lv = 1'b0; lwa = '0; lwd = '0;
        chk_a1 = '0; chk_a2 = '0;

        //   name        pwe pwa pwd     lv lwa lwd     ca  rdy stl hit we wa  wd
        add("bypass",    0, 0, 0,      1, 5, 32'hCAFE, 5,  1, 0, 0,  1, 5,  32'hCAFE);
        add("byp_idle",  0, 0, 0,      0, 0, 0,        5,  1, 0, 1,  0, 5,  32'hCAFE);
        add("conf_both", 1, 3, 32'h11, 1, 7, 32'h22,   7,  1, 0, 0,  1, 3,  32'h11);
        add("conf_pop",  0, 0, 0,      0, 0, 0,        7,  1, 0, 1,  1, 7,  32'h22);
        add("conf_we",   0, 0, 0,      0, 0, 0,        7,  1, 0, 1,  0, 7,  32'h22);
        add("conf_done", 0, 0, 0,      0, 0, 0,        7,  1, 0, 0,  0, 7,  32'h22);
        add("zero_lwa",  0, 0, 0,      1, 0, 32'h99,   0,  1, 0, 0,  0, 7,  32'h22);
        add("zero_pwa",  1, 0, 32'h55, 0, 0, 0,        0,  1, 0, 0,  0, 7,  32'h22);
        add("zero_idle", 0, 0, 0,      0, 0, 0,        7,  1, 0, 0,  0, 7,  32'h22);
        add("fill1",     1, 1, 32'h101, 1, 10, 32'hA0, 10, 1, 0, 0,  1, 1,  32'h101);
        add("fill2",     1, 2, 32'h102, 1, 11, 32'hA1, 10, 1, 0, 1,  1, 2,  32'h102);
        add("fill3",     1, 3, 32'h103, 1, 12, 32'hA2, 12, 1, 0, 0,  1, 3,  32'h103);
        add("fill4",     1, 4, 32'h104, 1, 13, 32'hA3, 11, 1, 0, 1,  1, 4,  32'h104);
        add("fill_full", 1, 5, 32'h105, 1, 14, 32'hA4, 13, 0, 1, 1,  1, 5,  32'h105);
        add("drain1",    0, 0, 0,      0, 0, 0,        14, 0, 1, 0,  1, 10, 32'hA0);
        add("drain2",    0, 0, 0,      0, 0, 0,        10, 1, 0, 1,  1, 11, 32'hA1);
        add("drain3",    0, 0, 0,      0, 0, 0,        0,  1, 0, 0,  1, 12, 32'hA2);
        add("drain4",    0, 0, 0,      0, 0, 0,        12, 1, 0, 1,  1, 13, 32'hA3);
        add("drain_end", 0, 0, 0,      0, 0, 0,        13, 1, 0, 1,  0, 13, 32'hA3);
        add("starve0",   1, 6, 32'h600, 1, 20, 32'hB0, 20, 1, 0, 0,  1, 6,  32'h600);
        for (int k = 1; k <= 9; k++)
            add($sformatf("starve%0d", k), 1, 6, 32'h600 + k, 0, 0, 0, 20, 1, (k == 9), 1,
                1, 6, 32'h600 + k);
        add("starve_pop", 0, 0, 0,     0, 0, 0,        20, 1, 1, 1,  1, 20, 32'hB0);
        add("starve_clr", 0, 0, 0,     0, 0, 0,        20, 1, 0, 1,  0, 20, 32'hB0);
        add("queue1",    1, 1, 32'h701, 1, 21, 32'hC1, 21, 1, 0, 0,  1, 1,  32'h701);
        add("queue2",    1, 2, 32'h702, 1, 22, 32'hC2, 21, 1, 0, 1,  1, 2,  32'h702);
        add("queue3",    1, 3, 32'h703, 1, 23, 32'hC3, 22, 1, 0, 1,  1, 3,  32'h703);

        repeat (2) @(posedge clk);
        #1;
        check("rst.we", we, 0);
        check("rst.wa", wa, 0);
        check("rst.wd", wd, 0);
        check("rst.lrdy", lrdy, 0);
        check("rst.stall", stall_req, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            pwe = vecs[i].pwe; pwa = vecs[i].pwa; pwd = vecs[i].pwd;
            lv  = vecs[i].lv;  lwa = vecs[i].lwa; lwd = vecs[i].lwd;
            chk_a1 = vecs[i].ca; chk_a2 = vecs[i].ca;
            e.name = vecs[i].name; e.we = vecs[i].we; e.wa = vecs[i].wa; e.wd = vecs[i].wd;
            sb.push_back(e);
            #1;
            check({vecs[i].name, ".lrdy"}, lrdy, vecs[i].lrdy);
            check({vecs[i].name, ".stall"}, stall_req, vecs[i].stall);
            check({vecs[i].name, ".hit1"}, chk_hit1, vecs[i].hit);
            check({vecs[i].name, ".hit2"}, chk_hit2, vecs[i].hit);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({e.name, ".we"}, we, e.we);
            check({e.name, ".wa"}, wa, e.wa);
            check({e.name, ".wd"}, wd, e.wd);
            $display("vec %-10s we=%0d wa=%0d wd=0x%0h lrdy=%0d stall=%0d",
                     e.name, we, wa, wd, lrdy, stall_req);
        end

        // Three results are queued; reset must discard them all.
        @(negedge clk);
        pwe = 1'b0; lv = 1'b0; chk_a1 = 5'd23; chk_a2 = 5'd0;
        #1;
        check("prerst.hit1", chk_hit1, 1);
        check("prerst.lrdy", lrdy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst.we", we, 0);
        check("midrst.wa", wa, 0);
        check("midrst.wd", wd, 0);
        check("midrst.lrdy", lrdy, 0);
        check("midrst.stall", stall_req, 0);
        @(posedge clk);
        #1;
        check("midrst_hold.we", we, 0);
        check("midrst_hold.lrdy", lrdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst.lrdy", lrdy, 1);
        check("postrst.stall", stall_req, 0);
        for (int a = 21; a <= 23; a++) begin
            chk_a1 = 5'(a);
            #1;
            check($sformatf("postrst.hit1_r%0d", a), chk_hit1, 0);
        end
        @(posedge clk);
        #1;
        check("postrst.we", we, 0);
        $display("reset sequence done: we=%0d lrdy=%0d", we, lrdy);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
